// File: rtl/hexagon_pkg.sv
// ---------------------------------------------------------------------------
// hexagon_pkg
// Shared definitions for the game timebase logic.
//   - state_e    : controller state encoding (IDLE=0, RUN=1)
//   - PERIOD_W   : width of step-period arithmetic (clocks)
//   - TIME_W     : width of the survival timer (tenths of a second)
//   - LEVEL_W    : width of the speed level
//   - DIFF_*     : difficulty code constants
// ---------------------------------------------------------------------------
package hexagon_pkg;

  localparam int PERIOD_W = 24;
  localparam int TIME_W   = 16;
  localparam int LEVEL_W  = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [1:0] DIFF_EASY   = 2'd0;
  localparam logic [1:0] DIFF_NORMAL = 2'd1;
  localparam logic [1:0] DIFF_HARD   = 2'd2;
  localparam logic [1:0] DIFF_EXPERT = 2'd3;

  localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;
  localparam logic [TIME_W-1:0]  TIME_MAX  = '1;

endpackage

// File: rtl/pulse_divider.sv
// ---------------------------------------------------------------------------
// pulse_divider
// Modulo-N counter with enable and synchronous clear. o_tc is high for the
// single enabled cycle in which the count sits at N-1; the counter wraps to 0
// on that same edge.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   i_en   in  count enable
//   i_clr  in  synchronous clear (wins over enable)
//   o_tc   out terminal-count strobe (combinational, qualified by i_en)
// ---------------------------------------------------------------------------
module pulse_divider #(
  parameter int unsigned N = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tc
);

  localparam int unsigned       CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(N - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tc = i_en & (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tc ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/speed_controller.sv
// ---------------------------------------------------------------------------
// speed_controller
// Game movement timebase. Converts the difficulty code into a one-cycle step
// strobe, speeds the strobe up every RAMP_STEPS steps (speed levels), and
// keeps a saturating survival timer in tenths of a second.
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   gameover      in   high while the game is stopped / selection screen
//   difficulty    in   [1:0] difficulty code, sampled on the start edge
//   step          out  one-cycle strobe: advance obstacles one step
//   level         out  [3:0] current speed level 0..15
//   period        out  [23:0] current step period in clocks
//   survive_time  out  [15:0] elapsed run time in tenths of a second
//   running       out  high while in RUN
// ---------------------------------------------------------------------------
module speed_controller
  import hexagon_pkg::*;
#(
  parameter int unsigned TENTH_DIV  = 5000000,
  parameter int unsigned PERIOD_D0  = 800000,
  parameter int unsigned PERIOD_D1  = 600000,
  parameter int unsigned PERIOD_D2  = 450000,
  parameter int unsigned PERIOD_D3  = 300000,
  parameter int unsigned RAMP_STEPS = 64,
  parameter int unsigned RAMP_DEC   = 20000,
  parameter int unsigned MIN_PERIOD = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                gameover,
  input  logic [1:0]          difficulty,
  output logic                step,
  output logic [LEVEL_W-1:0]  level,
  output logic [PERIOD_W-1:0] period,
  output logic [TIME_W-1:0]   survive_time,
  output logic                running
);

  localparam logic [PERIOD_W-1:0] P_D0  = PERIOD_W'(PERIOD_D0);
  localparam logic [PERIOD_W-1:0] P_D1  = PERIOD_W'(PERIOD_D1);
  localparam logic [PERIOD_W-1:0] P_D2  = PERIOD_W'(PERIOD_D2);
  localparam logic [PERIOD_W-1:0] P_D3  = PERIOD_W'(PERIOD_D3);
  localparam logic [PERIOD_W-1:0] P_DEC = PERIOD_W'(RAMP_DEC);
  localparam logic [PERIOD_W-1:0] P_MIN = PERIOD_W'(MIN_PERIOD);

  localparam int unsigned        RAMP_W    = (RAMP_STEPS > 1) ? $clog2(RAMP_STEPS) : 1;
  localparam logic [RAMP_W-1:0]  RAMP_LAST = RAMP_W'(RAMP_STEPS - 1);

  // Level-0 step period for a difficulty code.
  function automatic logic [PERIOD_W-1:0] period_for(input logic [1:0] d);
    logic [PERIOD_W-1:0] p;
    case (d)
      DIFF_EASY:   p = P_D0;
      DIFF_NORMAL: p = P_D1;
      DIFF_HARD:   p = P_D2;
      DIFF_EXPERT: p = P_D3;
      default:     p = P_D0;
    endcase
    return p;
  endfunction

  // Next-level period: subtract RAMP_DEC but never go below MIN_PERIOD.
  // The comparison is done on the headroom above the floor so the
  // subtraction can never wrap.
  function automatic logic [PERIOD_W-1:0] next_period(input logic [PERIOD_W-1:0] p);
    logic [PERIOD_W-1:0] n;
    if ((p > P_MIN) && ((p - P_MIN) > P_DEC)) begin
      n = p - P_DEC;
    end else begin
      n = P_MIN;
    end
    return n;
  endfunction

  state_e              r_state;
  logic                r_gameover_q;
  logic [PERIOD_W-1:0] r_step_cnt;
  logic [RAMP_W-1:0]   r_ramp_cnt;
  logic                r_step;
  logic [LEVEL_W-1:0]  r_level;
  logic [PERIOD_W-1:0] r_period;
  logic [TIME_W-1:0]   r_survive;
  logic                r_running;

  logic w_start;
  logic w_run_en;
  logic w_step_tc;
  logic w_ramp_tc;
  logic w_tenth_clr;
  logic w_tenth_tc;

  assign w_start   = r_gameover_q & ~gameover;

  // gameover gates all run-time activity in the same cycle it rises, so a
  // coinciding terminal count never produces a step or a level change.
  assign w_run_en  = (r_state == ST_RUN) & ~gameover;
  assign w_step_tc = w_run_en & (r_step_cnt == (r_period - PERIOD_W'(1)));
  assign w_ramp_tc = (r_ramp_cnt == RAMP_LAST);

  assign w_tenth_clr = (r_state == ST_IDLE) & w_start;

  pulse_divider #(
    .N (TENTH_DIV)
  ) u_tenth_div (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_run_en),
    .i_clr (w_tenth_clr),
    .o_tc  (w_tenth_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_gameover_q <= 1'b1;
      r_step_cnt   <= '0;
      r_ramp_cnt   <= '0;
      r_step       <= 1'b0;
      r_level      <= '0;
      r_period     <= P_D0;
      r_survive    <= '0;
      r_running    <= 1'b0;
    end else begin
      r_gameover_q <= gameover;
      r_step       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // level/period/survive_time hold so the final score stays visible
          if (w_start) begin
            r_state    <= ST_RUN;
            r_running  <= 1'b1;
            r_period   <= period_for(difficulty);
            r_level    <= '0;
            r_survive  <= '0;
            r_step_cnt <= '0;
            r_ramp_cnt <= '0;
          end
        end
        ST_RUN: begin
          if (gameover) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
          end else begin
            if (w_step_tc) begin
              r_step     <= 1'b1;
              r_step_cnt <= '0;
              // A new period is loaded at the same edge the counter wraps,
              // so it governs the following interval only.
              if (w_ramp_tc) begin
                r_ramp_cnt <= '0;
                r_period   <= next_period(r_period);
                if (r_level != LEVEL_MAX) begin
                  r_level <= r_level + LEVEL_W'(1);
                end
              end else begin
                r_ramp_cnt <= r_ramp_cnt + RAMP_W'(1);
              end
            end else begin
              r_step_cnt <= r_step_cnt + PERIOD_W'(1);
            end
            if (w_tenth_tc && (r_survive != TIME_MAX)) begin
              r_survive <= r_survive + TIME_W'(1);
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign step         = r_step;
  assign level        = r_level;
  assign period       = r_period;
  assign survive_time = r_survive;
  assign running      = r_running;

endmodule

// File: tb/tb_speed_controller.sv
// ---------------------------------------------------------------------------
// tb_speed_controller
// Directed bench for speed_controller with small timing parameters.
// Expected step events (cycle, level, period) are queued when a game is
// started; a monitor pops one entry for every step pulse the DUT produces.
// ---------------------------------------------------------------------------
module tb_speed_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        gameover;
  logic [1:0]  difficulty;
  logic        step;
  logic [3:0]  level;
  logic [23:0] period;
  logic [15:0] survive_time;
  logic        running;

  speed_controller #(
    .TENTH_DIV  (10),
    .PERIOD_D0  (40),
    .PERIOD_D1  (30),
    .PERIOD_D2  (20),
    .PERIOD_D3  (12),
    .RAMP_STEPS (4),
    .RAMP_DEC   (6),
    .MIN_PERIOD (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .gameover     (gameover),
    .difficulty   (difficulty),
    .step         (step),
    .level        (level),
    .period       (period),
    .survive_time (survive_time),
    .running      (running)
  );

  always #5 clk = ~clk;

  typedef struct {
    int t;
    int lvl;
    int per;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   cyc = 0;
  int   base = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Wait until the negedge that follows posedge number base+e of this game.
  task automatic wait_rel(input int e);
    while (cyc < base + e) @(negedge clk);
  endtask

  task automatic push(input int t, input int lvl, input int per);
    exp_t x;
    x.t = base + t;
    x.lvl = lvl;
    x.per = per;
    q.push_back(x);
  endtask

  // Drop gameover on a negedge; the following posedge is the start edge.
  task automatic start_game(input logic [1:0] d);
    difficulty = d;
    repeat (3) @(negedge clk);
    gameover = 1'b0;
    base = cyc + 1;
  endtask

  // Monitor: every step pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && step === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_step: step=1 at cycle %0d, expected no step", cyc);
      end else begin
        m_e = q.pop_front();
        chk("step_cycle", cyc, m_e.t);
        chk("step_level", {28'd0, level}, m_e.lvl);
        chk("step_period", {8'd0, period}, m_e.per);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    gameover = 1'b1;
    difficulty = 2'd0;
    repeat (2) @(negedge clk);

    // 1: reset values, then idle with gameover held
    chk("rst_step", step, 0);
    chk("rst_running", running, 0);
    chk("rst_level", level, 0);
    chk("rst_period", period, 40);
    chk("rst_survive", survive_time, 0);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("idle_running", running, 0);
    chk("idle_level", level, 0);
    chk("idle_period", period, 40);
    chk("idle_survive", survive_time, 0);

    // 2: difficulty 2, period 20; ramp after 4 steps -> 14
    start_game(2'd2);
    push(20, 0, 20);
    push(40, 0, 20);
    push(60, 0, 20);
    push(80, 1, 14);
    chk("g2_running_pre", running, 0);
    wait_rel(0);
    chk("g2_running", running, 1);
    chk("g2_period", period, 20);
    wait_rel(9);
    chk("g2_surv9", survive_time, 0);
    wait_rel(10);
    chk("g2_surv10", survive_time, 1);
    wait_rel(50);
    chk("g2_surv50", survive_time, 5);
    wait_rel(89);
    chk("g2_surv89", survive_time, 8);
    wait_rel(90);
    gameover = 1'b1;
    wait_rel(91);
    chk("g2_end_running", running, 0);
    chk("g2_end_level", level, 1);
    chk("g2_end_period", period, 14);
    chk("g2_end_survive", survive_time, 9);
    chk("g2_all_steps_seen", q.size(), 0);

    // 3: difficulty 3, period 12 floors to 8; level saturates at 15
    start_game(2'd3);
    for (int k = 1; k <= 64; k++) begin
      push(12 * ((k < 4) ? k : 4) + 8 * ((k > 4) ? k - 4 : 0),
           ((k / 4) > 15) ? 15 : (k / 4),
           (k < 4) ? 12 : 8);
    end
    wait_rel(0);
    chk("g3_level0", level, 0);
    chk("g3_period0", period, 12);
    chk("g3_survive0", survive_time, 0);
    wait_rel(530);
    gameover = 1'b1;
    wait_rel(531);
    chk("g3_end_level", level, 15);
    chk("g3_end_period", period, 8);
    chk("g3_end_survive", survive_time, 53);
    chk("g3_end_running", running, 0);
    chk("g3_all_steps_seen", q.size(), 0);

    // 4: difficulty 1, gameover coincides with terminal count -> no step
    start_game(2'd1);
    wait_rel(0);
    chk("g4_period", period, 30);
    chk("g4_level", level, 0);
    wait_rel(29);
    gameover = 1'b1;
    wait_rel(30);
    chk("g4_tc_step", step, 0);
    chk("g4_tc_running", running, 0);
    chk("g4_tc_level", level, 0);
    chk("g4_tc_period", period, 30);
    chk("g4_tc_survive", survive_time, 2);
    repeat (20) @(negedge clk);
    chk("g4_frozen_level", level, 0);
    chk("g4_frozen_period", period, 30);
    chk("g4_frozen_survive", survive_time, 2);

    // 5: difficulty 0 selected while stopped; fresh game
    start_game(2'd0);
    push(40, 0, 40);
    wait_rel(0);
    chk("g5_running", running, 1);
    chk("g5_period", period, 40);
    chk("g5_level", level, 0);
    chk("g5_survive", survive_time, 0);
    wait_rel(50);
    chk("g5_surv50", survive_time, 5);

    // 6: asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_step", step, 0);
    chk("arst_running", running, 0);
    chk("arst_period", period, 40);
    chk("arst_level", level, 0);
    chk("arst_survive", survive_time, 0);
    chk("g5_all_steps_seen", q.size(), 0);
    gameover = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
